// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one 4-digit seven-segment display between three requesters. A
// round-robin arbiter grants the display to one requester at a time. The grant
// lasts DWELL clock cycles, or ends early if the owner drops its request. The
// winner's 16-bit value is captured on the grant edge and held until the next
// grant. This means the display never blanks and never follows live data.
//
// Ports
//   i_clk        system clock, rising-edge active
//   i_rst        asynchronous active-high reset
//   i_req[2:0]   per-requester display request
//   i_data0..2   requester values, four hex nibbles (digit 0 in [3:0])
//   o_gnt[2:0]   one-hot grant, high while the requester owns the display
//   o_ack[2:0]   one-cycle pulse when the owner's dwell completes normally
//   o_disp_data  registered value for the seven-segment driver
//   o_busy       high while a grant is active (SHOW)
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; arbitrate among requesters each cycle
// SHOW    | one requester owns the display; dwell counter running
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter logic [31:0] DWELL = 32'd100_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_req,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    input  logic [15:0] i_data2,
    output logic [2:0]  o_gnt,
    output logic [2:0]  o_ack,
    output logic [15:0] o_disp_data,
    output logic        o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [1:0]  r_win;
    logic [1:0]  w_win_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [2:0]  r_gnt;
    logic [2:0]  w_gnt_nxt;
    logic [2:0]  r_ack;
    logic [2:0]  w_ack_nxt;
    logic [15:0] r_disp;
    logic [15:0] w_disp_nxt;

    logic        w_rr_valid;
    logic [1:0]  w_rr_win;
    logic [15:0] w_rr_data;
    logic        w_released;
    logic        w_dwell_done;

    // Round-robin pick. The search starts one past the last owner and wraps.
    // Reset leaves r_last at 2, so requester 0 has the highest priority first.
    always_comb begin
        w_rr_valid = (i_req != 3'b000);
        w_rr_win   = 2'd0;
        case (r_last)
            2'd0: begin
                if (i_req[1])      w_rr_win = 2'd1;
                else if (i_req[2]) w_rr_win = 2'd2;
                else               w_rr_win = 2'd0;
            end
            2'd1: begin
                if (i_req[2])      w_rr_win = 2'd2;
                else if (i_req[0]) w_rr_win = 2'd0;
                else               w_rr_win = 2'd1;
            end
            default: begin
                if (i_req[0])      w_rr_win = 2'd0;
                else if (i_req[1]) w_rr_win = 2'd1;
                else               w_rr_win = 2'd2;
            end
        endcase
    end

    always_comb begin
        case (w_rr_win)
            2'd0:    w_rr_data = i_data0;
            2'd1:    w_rr_data = i_data1;
            default: w_rr_data = i_data2;
        endcase
    end

    // The owner's request is checked through the one-hot grant, so r_win is
    // never used as an index into i_req.
    assign w_released   = ((r_gnt & i_req) == 3'b000);
    assign w_dwell_done = (r_cnt == (DWELL - 32'd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd2;
            r_win   <= 2'd0;
            r_cnt   <= 32'd0;
            r_gnt   <= 3'b000;
            r_ack   <= 3'b000;
            r_disp  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = 3'b000;
        w_disp_nxt  = r_disp;

        case (r_state)
            ST_IDLE: begin
                if (w_rr_valid) begin
                    w_state_nxt = ST_SHOW;
                    w_win_nxt   = w_rr_win;
                    w_gnt_nxt   = 3'b001 << w_rr_win;
                    w_disp_nxt  = w_rr_data;
                    w_cnt_nxt   = 32'd0;
                end
            end
            ST_SHOW: begin
                // A release wins over a dwell that completes on the same edge.
                // The grant did not finish normally, so no ack is produced.
                if (w_released) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 3'b000;
                    w_last_nxt  = r_win;
                    w_cnt_nxt   = 32'd0;
                end else if (w_dwell_done) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 3'b000;
                    w_ack_nxt   = r_gnt;
                    w_last_nxt  = r_win;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 3'b000;
            end
        endcase
    end

    assign o_gnt       = r_gnt;
    assign o_ack       = r_ack;
    assign o_disp_data = r_disp;
    assign o_busy      = (r_state == ST_SHOW);

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Bench for display_arbiter with DWELL=4. It runs directed scenarios first,
// then randomized traffic. The random phase is checked against an
// owner/remaining-cycles reference model.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int DW = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] data [3];
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [15:0] disp;
    logic        busy;

    int n_checks;
    int n_errors;

    display_arbiter #(.DWELL(32'(DW))) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_data0     (data[0]),
        .i_data1     (data[1]),
        .i_data2     (data[2]),
        .o_gnt       (gnt),
        .o_ack       (ack),
        .o_disp_data (disp),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Ownership is tracked as an owner index (-1 = none)
    // plus the number of grant cycles still to be shown.
    int          m_owner;
    int          m_left;
    int          m_last;
    logic [2:0]  m_ack;
    logic [15:0] m_disp;

    always @(posedge clk or posedge rst) begin
        int          own;
        int          left;
        int          last;
        logic [2:0]  a;
        logic [15:0] d;
        if (rst) begin
            m_owner <= -1;
            m_left  <= 0;
            m_last  <= 2;
            m_ack   <= 3'b000;
            m_disp  <= 16'h0000;
        end else begin
            own  = m_owner;
            left = m_left;
            last = m_last;
            a    = 3'b000;
            d    = m_disp;
            if (own < 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (own < 0 && req[(last + k) % 3]) own = (last + k) % 3;
                end
                if (own >= 0) begin
                    left = DW;
                    d    = data[own];
                end
            end else if (!req[own]) begin
                last = own;
                own  = -1;
            end else begin
                left = left - 1;
                if (left == 0) begin
                    a[own] = 1'b1;
                    last   = own;
                    own    = -1;
                end
            end
            m_owner <= own;
            m_left  <= left;
            m_last  <= last;
            m_ack   <= a;
            m_disp  <= d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL reset_ack got=%b exp=000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (disp !== 16'h0000) begin n_errors++; $display("FAIL reset_disp got=%h exp=0000", disp); end
        req = 3'b111;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL reset_hold_gnt got=%b exp=000", gnt); end
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single request, followed by data that changes mid-grant.
    task automatic test_single();
        do_reset();
        req     = 3'b001;
        data[0] = 16'h1234;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL single_gnt cyc=%0d got=%b exp=001", i, gnt); end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy); end
            n_checks++; if (disp !== 16'h1234) begin n_errors++; $display("FAIL single_disp cyc=%0d got=%h exp=1234", i, disp); end
            n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL single_ack_early cyc=%0d got=%b exp=000", i, ack); end
            if (i == 1) data[0] = 16'hBEEF;
        end
        @(negedge clk);
        n_checks++; if (ack !== 3'b001) begin n_errors++; $display("FAIL single_ack got=%b exp=001", ack); end
        n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL single_gnt_end got=%b exp=000", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        req = 3'b000;
        @(negedge clk);
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL single_ack_width got=%b exp=000", ack); end
    endtask

    task automatic test_data_freeze();
        @(negedge clk);
        n_checks++; if (disp !== 16'h1234) begin n_errors++; $display("FAIL freeze_idle_disp got=%h exp=1234", disp); end
        req = 3'b001;
        @(negedge clk);
        n_checks++; if (disp !== 16'hBEEF) begin n_errors++; $display("FAIL freeze_next_disp got=%h exp=beef", disp); end
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        do_reset();
        data[0] = 16'hA000;
        data[1] = 16'hB111;
        data[2] = 16'hC222;
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < DW; i++) begin
                @(negedge clk);
                n_checks++; if (gnt !== (3'b001 << order[g])) begin n_errors++; $display("FAIL rr_gnt g=%0d cyc=%0d got=%b exp=%b", g, i, gnt, 3'b001 << order[g]); end
                n_checks++; if (disp !== data[order[g]]) begin n_errors++; $display("FAIL rr_disp g=%0d got=%h exp=%h", g, disp, data[order[g]]); end
            end
            @(negedge clk);
            n_checks++; if (ack !== (3'b001 << order[g])) begin n_errors++; $display("FAIL rr_ack g=%0d got=%b exp=%b", g, ack, 3'b001 << order[g]); end
            n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL rr_gap g=%0d got=%b exp=000", g, gnt); end
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_early_release();
        do_reset();
        data[1] = 16'h5A5A;
        req = 3'b010;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL early_gnt1 got=%b exp=010", gnt); end
        @(negedge clk);
        n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL early_gnt2 got=%b exp=010", gnt); end
        req = 3'b000;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL early_gnt_drop got=%b exp=000", gnt); end
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL early_ack got=%b exp=000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL early_busy got=%b exp=0", busy); end
        n_checks++; if (disp !== 16'h5A5A) begin n_errors++; $display("FAIL early_disp got=%h exp=5a5a", disp); end
        @(negedge clk);
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL early_ack_late got=%b exp=000", ack); end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        data[0] = 16'h0F0F;
        data[2] = 16'h7777;
        req = 3'b100;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b100) begin n_errors++; $display("FAIL rstmid_gnt got=%b exp=100", gnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL rstmid_gnt_clr got=%b exp=000", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (disp !== 16'h0000) begin n_errors++; $display("FAIL rstmid_disp got=%h exp=0000", disp); end
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL rstmid_ack got=%b exp=000", ack); end
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL rstmid_first got=%b exp=001", gnt); end
        n_checks++; if (disp !== 16'h0F0F) begin n_errors++; $display("FAIL rstmid_first_disp got=%h exp=0f0f", disp); end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        req = 3'b100;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < DW; i++) begin
                @(negedge clk);
                n_checks++; if (gnt !== 3'b100) begin n_errors++; $display("FAIL wrap_gnt g=%0d cyc=%0d got=%b exp=100", g, i, gnt); end
            end
            @(negedge clk);
            n_checks++; if (ack !== 3'b100 || gnt !== 3'b000) begin n_errors++; $display("FAIL wrap_ack g=%0d got ack=%b gnt=%b exp ack=100 gnt=000", g, ack, gnt); end
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            exp_gnt = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
            n_checks++; if (gnt !== exp_gnt) begin n_errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
            n_checks++; if (ack !== m_ack) begin n_errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, ack, m_ack); end
            n_checks++; if (busy !== (m_owner >= 0)) begin n_errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_owner >= 0); end
            n_checks++; if (disp !== m_disp) begin n_errors++; $display("FAIL rand_disp cyc=%0d got=%h exp=%h", c, disp, m_disp); end
            n_checks++; if ((gnt & ack) !== 3'b000) begin n_errors++; $display("FAIL rand_overlap cyc=%0d got gnt=%b ack=%b exp overlap=000", c, gnt, ack); end
            if ($urandom_range(0, 2) == 0) req[$urandom_range(0, 2)] = ~req[$urandom_range(0, 2)];
            if ($urandom_range(0, 7) == 0) req = 3'($urandom);
            for (int k = 0; k < 3; k++) if ($urandom_range(0, 1) == 1) data[k] = 16'($urandom);
        end
        req = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = 3'b000;
        data[0]  = 16'h0000;
        data[1]  = 16'h0000;
        data[2]  = 16'h0000;
        test_reset();
        test_single();
        test_data_freeze();
        test_round_robin();
        test_early_release();
        test_reset_mid_show();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL, default 32'd100_000_000, is the number of clk cycles one grant holds the display; legal range 2..2^32-1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  per-requester display request; bit i belongs to requester i.
REQ-005 data0  input  16  requester 0 value: four hex nibbles, digit 0 in [3:0].
REQ-006 data1  input  16  requester 1 value, same format.
REQ-007 data2  input  16  requester 2 value, same format.
REQ-008 gnt  output  3  one-hot grant; bit i high while requester i owns the display.
REQ-009 ack  output  3  one-cycle pulse on bit i when requester i's dwell completes normally.
REQ-010 disp_data  output  16  registered value driven to the 4-digit seven-segment driver's data input.
REQ-011 busy  output  1  high while in SHOW.

Function
REQ-012 The FSM SHALL have two states, IDLE and SHOW.
REQ-013 In IDLE with req != 0, the block SHALL pick the winner round-robin, searching from (last+1) mod 3 upward with wrap, where last is the most recently granted requester.
REQ-014 On that edge the block SHALL set gnt to the winner's one-hot code, copy the winner's data into disp_data, clear the dwell counter, set busy=1 and enter SHOW; gnt and disp_data SHALL be visible the cycle after req is first sampled high.
REQ-015 In SHOW, disp_data SHALL hold the captured value; changes on data0..2 are ignored.
REQ-016 In SHOW, the dwell counter (32-bit) SHALL increment once per cycle; gnt SHALL stay high for exactly DWELL cycles.
REQ-017 When the counter equals DWELL-1, the next edge SHALL clear gnt and busy, set last to the winner, pulse ack[winner] for exactly one cycle (the first IDLE cycle) and return to IDLE.
REQ-018 If req[winner] is sampled low in SHOW, the next edge SHALL clear gnt and busy, update last, return to IDLE and leave ack at 0.
REQ-019 Requests from non-granted requesters in SHOW SHALL be ignored; no preemption.
REQ-020 The block SHALL spend at least one IDLE cycle between consecutive grants, so back-to-back grants are separated by exactly one cycle.
REQ-021 In IDLE, disp_data SHALL hold the last captured value, with no blanking.
REQ-022 gnt SHALL never have more than one bit set, and ack SHALL never be high in the same cycle as gnt.

Reset
REQ-023 While rst=1, regardless of clk: state=IDLE, gnt=3'b000, ack=3'b000, busy=0, disp_data=16'h0000, counter=0, last=2, so requester 0 wins first.
REQ-024 An assertion of rst during SHOW SHALL abort the grant immediately and produce no ack.
REQ-025 The first rising edge after rst falls SHALL be able to issue a grant.

Verification (DWELL=4)
REQ-026 Single request: reset, then req=001 with data0=16'h1234 -> next cycle gnt=001, busy=1 and disp_data=16'h1234 for 4 cycles -> then ack=001 for 1 cycle with gnt=000.
REQ-027 Round-robin: req=111 held -> grant order 0,1,2,0 -> each grant 4 cycles, with 1 IDLE cycle (ack pulse) between grants.
REQ-028 Data freeze: during a grant to requester 0, data0 changes to 16'hBEEF -> disp_data stays 16'h1234 until the next grant.
REQ-029 Early release: req[1] drops in the 2nd SHOW cycle -> gnt=000 on the next cycle, ack stays 000, disp_data keeps the captured value.
REQ-030 Reset mid-SHOW: rst pulses during the grant to requester 2 -> outputs go to 0 immediately with no ack; after release, req=111 -> requester 0 is granted first.
REQ-031 Wrap: reset, then only req=100 held -> repeated grants to requester 2, with last wrapping and no grant ever issued to requesters 0 or 1.
